// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control FSM.
// The ADDI states exist only when MCU_ADDI_EN is defined.
package mcu_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
`ifdef MCU_ADDI_EN
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12
`else
    StJump   = 4'd10
`endif
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpNop   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

endpackage

// File: rtl/mcu_mem_timer.sv
// Memory wait-state counter; flags expiry when MEM_TIMEOUT consecutive not-ready
// cycles have elapsed in a memory state. MEM_TIMEOUT of 0 never expires.
module mcu_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  localparam logic [TMR_W-1:0] Limit  = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] CntMax = '1;

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Saturate so a disabled timeout cannot wrap into a spurious match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || ready) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && en && !ready && (cnt_q == Limit);

endmodule

// File: rtl/mcu_multicycle.sv
// Multi-cycle main control FSM for the shared-memory MIPS-subset datapath.
// Optional addi support is enabled by defining MCU_ADDI_EN.
module mcu_multicycle
  import mcu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       tmr_en, tmr_clr, expired;

  assign tmr_en  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A FETCH timeout stays in FETCH, so expiry must clear the counter explicitly.
  assign tmr_clr = (state_d != state_q) || expired;

  mcu_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (clr),
    .en     (tmr_en),
    .ready  (mem_ready),
    .clr    (tmr_clr),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= OP;
    end
  end

  always_comb begin
    state_d     = state_q;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PcAlu;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SrcBRt;
    ALUOp       = AluAdd;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (expired) begin
          mem_err = 1'b1;
          state_d = StFetch;
        end
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh;
        case (OP)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpNop: begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
`ifdef MCU_ADDI_EN
          OpAddi:     state_d = StAddiEx;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (expired) begin
          mem_err = 1'b1;
          state_d = StFetch;
        end
      end
      StMemWb: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (expired) begin
          mem_err = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluFunct;
        state_d = StRwb;
      end
      StRwb: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = AluSub;
        PCWriteCond = 1'b1;
        PCSource    = PcAluOut;
        instr_done  = 1'b1;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite    = 1'b1;
        PCSource   = PcJump;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`ifdef MCU_ADDI_EN
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mcu_multicycle.sv
// Scoreboard bench for mcu_multicycle: each step queues the expected state and
// control word, then compares them against the DUT mid-cycle.
module tb_mcu_multicycle;
  import mcu_pkg::*;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       done;
    logic       illegal;
    logic       err;
  } ctl_t;

  localparam logic [2:0] PN = 3'b000;
  localparam logic [2:0] PD = 3'b100;
  localparam logic [2:0] PI = 3'b010;
  localparam logic [2:0] PE = 3'b001;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [5:0] OP = '0;
  logic       mem_ready = 1'b0;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegWrite, RegDst, MemtoReg;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  ctl_t       exp_ctl_q[$];
  logic [3:0] exp_st_q[$];

  mcu_multicycle #(
    .MEM_TIMEOUT(15),
    .TMR_W      (4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource   (PCSource),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c.mem_read      = MemRead;
    c.mem_write     = MemWrite;
    c.iord          = IorD;
    c.ir_write      = IRWrite;
    c.pc_write      = PCWrite;
    c.pc_write_cond = PCWriteCond;
    c.pc_source     = PCSource;
    c.alu_src_a     = ALUSrcA;
    c.alu_src_b     = ALUSrcB;
    c.alu_op        = ALUOp;
    c.reg_write     = RegWrite;
    c.reg_dst       = RegDst;
    c.mem_to_reg    = MemtoReg;
    c.done          = instr_done;
    c.illegal       = illegal_op;
    c.err           = mem_err;
    return c;
  endfunction

  // Expected per-state controls, written straight from the control table.
  function automatic ctl_t expected(input logic [3:0] st, input logic rdy, input logic [2:0] pl);
    ctl_t c = '0;
    if (st == 4'(StFetch)) begin
      c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    end else if (st == 4'(StDecode)) begin
      c.alu_src_b = 2'b11;
    end else if (st == 4'(StMemAdr)) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    end else if (st == 4'(StMemRd)) begin
      c.mem_read = 1'b1; c.iord = 1'b1;
    end else if (st == 4'(StMemWb)) begin
      c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
    end else if (st == 4'(StMemWr)) begin
      c.mem_write = 1'b1; c.iord = 1'b1;
    end else if (st == 4'(StExec)) begin
      c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    end else if (st == 4'(StRwb)) begin
      c.reg_write = 1'b1; c.reg_dst = 1'b1;
    end else if (st == 4'(StBranch)) begin
      c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
    end else if (st == 4'(StJump)) begin
      c.pc_write = 1'b1; c.pc_source = 2'b10;
`ifdef MCU_ADDI_EN
    end else if (st == 4'(StAddiEx)) begin
      c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    end else if (st == 4'(StAddiWb)) begin
      c.reg_write = 1'b1;
`endif
    end
    c.done    = pl[2];
    c.illegal = pl[1];
    c.err     = pl[0];
    return c;
  endfunction

  task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [2:0] pl);
    ctl_t       e;
    logic [3:0] es;
    exp_ctl_q.push_back(expected(st, rdy, pl));
    exp_st_q.push_back(st);
    OP        = op;
    mem_ready = rdy;
    @(negedge clk);
    e  = exp_ctl_q.pop_front();
    es = exp_st_q.pop_front();
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".ctrl"}, 32'(observed()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.state", 32'(state), 32'(4'(StIdle)));
    check("reset.ctrl", 32'(observed()), 32'h0);
    @(posedge clk);
    #1 clr = 1'b1;

    // R-type with zero wait states
    step("rt.idle", OpRtype, 1'b1, 4'(StIdle), PN);
    step("rt.fetch", OpRtype, 1'b1, 4'(StFetch), PN);
    step("rt.decode", OpRtype, 1'b1, 4'(StDecode), PN);
    step("rt.exec", OpRtype, 1'b1, 4'(StExec), PN);
    step("rt.rwb", OpRtype, 1'b1, 4'(StRwb), PD);

    // lw with two wait cycles; OP disturbed after DECODE must be ignored
    step("lw.fetch", OpLw, 1'b1, 4'(StFetch), PN);
    step("lw.decode", OpLw, 1'b1, 4'(StDecode), PN);
    step("lw.memadr", OpSw, 1'b1, 4'(StMemAdr), PN);
    step("lw.memrd0", OpSw, 1'b0, 4'(StMemRd), PN);
    step("lw.memrd1", OpSw, 1'b0, 4'(StMemRd), PN);
    step("lw.memrd2", OpSw, 1'b1, 4'(StMemRd), PN);
    step("lw.memwb", OpSw, 1'b1, 4'(StMemWb), PD);

    step("beq.fetch", OpBeq, 1'b1, 4'(StFetch), PN);
    step("beq.decode", OpBeq, 1'b1, 4'(StDecode), PN);
    step("beq.branch", OpBeq, 1'b1, 4'(StBranch), PD);
    step("j.fetch", OpJ, 1'b1, 4'(StFetch), PN);
    step("j.decode", OpJ, 1'b1, 4'(StDecode), PN);
    step("j.jump", OpJ, 1'b1, 4'(StJump), PD);

    step("nop.fetch", OpNop, 1'b1, 4'(StFetch), PN);
    step("nop.decode", OpNop, 1'b1, 4'(StDecode), PD);
    step("ill.fetch", 6'b111111, 1'b1, 4'(StFetch), PN);
    step("ill.decode", 6'b111111, 1'b1, 4'(StDecode), PI);

    step("addi.fetch", OpAddi, 1'b1, 4'(StFetch), PN);
`ifdef MCU_ADDI_EN
    step("addi.decode", OpAddi, 1'b1, 4'(StDecode), PN);
    step("addi.ex", OpAddi, 1'b1, 4'(StAddiEx), PN);
    step("addi.wb", OpAddi, 1'b1, 4'(StAddiWb), PD);
`else
    step("addi.decode", OpAddi, 1'b1, 4'(StDecode), PI);
`endif

    // Fetch timeout retries the fetch
    for (int i = 0; i < 15; i++) step("fto.wait", OpNop, 1'b0, 4'(StFetch), PN);
    step("fto.hit", OpNop, 1'b0, 4'(StFetch), PE);
    step("fto.retry", OpNop, 1'b1, 4'(StFetch), PN);
    step("fto.decode", OpNop, 1'b1, 4'(StDecode), PD);

    // sw timeout: mem_err on the 16th not-ready cycle, no instr_done
    step("swto.fetch", OpSw, 1'b1, 4'(StFetch), PN);
    step("swto.decode", OpSw, 1'b1, 4'(StDecode), PN);
    step("swto.memadr", OpLw, 1'b1, 4'(StMemAdr), PN);
    for (int i = 0; i < 15; i++) step("swto.wait", OpLw, 1'b0, 4'(StMemWr), PN);
    step("swto.hit", OpLw, 1'b0, 4'(StMemWr), PE);

    // Ready on the timeout cycle completes normally
    step("swrdy.fetch", OpSw, 1'b1, 4'(StFetch), PN);
    step("swrdy.decode", OpSw, 1'b1, 4'(StDecode), PN);
    step("swrdy.memadr", OpSw, 1'b1, 4'(StMemAdr), PN);
    for (int i = 0; i < 15; i++) step("swrdy.wait", OpSw, 1'b0, 4'(StMemWr), PN);
    step("swrdy.hit", OpSw, 1'b1, 4'(StMemWr), PD);

    // Asynchronous reset in the middle of MEMWR
    step("arst.fetch", OpSw, 1'b1, 4'(StFetch), PN);
    step("arst.decode", OpSw, 1'b1, 4'(StDecode), PN);
    step("arst.memadr", OpSw, 1'b1, 4'(StMemAdr), PN);
    step("arst.memwr", OpSw, 1'b0, 4'(StMemWr), PN);
    #2 clr = 1'b0;
    #1;
    check("arst.state", 32'(state), 32'(4'(StIdle)));
    check("arst.ctrl", 32'(observed()), 32'h0);
    @(posedge clk);
    #1 clr = 1'b1;
    step("arst.idle", OpRtype, 1'b1, 4'(StIdle), PN);
    step("arst.refetch", OpRtype, 1'b1, 4'(StFetch), PN);
    step("arst.decode2", OpRtype, 1'b1, 4'(StDecode), PN);
    step("arst.exec", OpRtype, 1'b1, 4'(StExec), PN);
    step("arst.rwb", OpRtype, 1'b1, 4'(StRwb), PD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
